// File: rtl/prim_pad_attr_seq.sv
// Pad attribute sequencer: gates a pad's output enable for S cycles, applies the masked attribute, then holds S more cycles.
// Accepts one request in IDLE (done after 2S+2 cycles, or next cycle for no-op/error); req_ready_o is low while busy.
module prim_pad_attr_seq #(
  parameter int unsigned          NumPads      = 8,
  parameter int unsigned          AttrDw       = 8,
  parameter logic [AttrDw-1:0]    AttrWarlMask = 8'h05,
  parameter logic [NumPads-1:0]   PadIsAnalog  = '0,
  parameter int unsigned          SettleCycles = 4,
  localparam int unsigned         IdxW         = (NumPads > 1) ? $clog2(NumPads) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_i,
  output logic                        req_ready_o,
  input  logic [IdxW-1:0]             req_idx_i,
  input  logic [AttrDw-1:0]           req_attr_i,
  output logic [NumPads*AttrDw-1:0]   attr_warl_o,
  output logic [NumPads*AttrDw-1:0]   pad_attr_o,
  output logic [NumPads-1:0]          pad_oe_gate_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int unsigned S       = (SettleCycles > 0) ? SettleCycles : 1;
  localparam logic [7:0]  CntInit = 8'(S - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    APPLY = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e                          r_state;
  logic [7:0]                      r_cnt;
  logic [IdxW-1:0]                 r_idx;
  logic [AttrDw-1:0]               r_masked;
  logic [NumPads-1:0][AttrDw-1:0]  r_attr;
  logic [NumPads-1:0]              r_gate;
  logic                            r_busy;
  logic                            r_done;
  logic                            r_err;

  logic                            w_idx_ok;
  logic [AttrDw-1:0]               w_warl;
  logic [AttrDw-1:0]               w_cur;
  logic [AttrDw-1:0]               w_masked;
  logic [NumPads-1:0]              w_onehot;
  logic                            w_accept;

  for (genvar g = 0; g < NumPads; g++) begin : g_warl
    assign attr_warl_o[g*AttrDw +: AttrDw] = PadIsAnalog[g] ? '0 : AttrWarlMask;
  end

  // Index decode by loop so an out-of-range index simply matches no pad.
  always_comb begin
    w_idx_ok = 1'b0;
    w_warl   = '0;
    w_cur    = '0;
    w_onehot = '0;
    for (int i = 0; i < NumPads; i++) begin
      if (req_idx_i == IdxW'(i)) begin
        w_idx_ok    = 1'b1;
        w_warl      = PadIsAnalog[i] ? '0 : AttrWarlMask;
        w_cur       = r_attr[i];
        w_onehot[i] = 1'b1;
      end
    end
    w_masked = req_attr_i & w_warl;
  end

  assign w_accept = req_i & ~r_busy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_masked <= '0;
      r_attr   <= '0;
      r_gate   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (!w_idx_ok) begin
              r_err <= 1'b1;
            end else begin
              r_idx    <= req_idx_i;
              r_masked <= w_masked;
              if (w_masked == w_cur) begin
                r_done <= 1'b1;
              end else begin
                r_state <= GATE;
                r_busy  <= 1'b1;
                r_cnt   <= CntInit;
                r_gate  <= w_onehot;
              end
            end
          end
        end
        GATE: begin
          if (r_cnt == 8'd0) begin
            r_state <= APPLY;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        APPLY: begin
          for (int i = 0; i < NumPads; i++) begin
            if (r_idx == IdxW'(i)) begin
              r_attr[i] <= r_masked;
            end
          end
          r_state <= HOLD;
          r_cnt   <= CntInit;
        end
        HOLD: begin
          if (r_cnt == 8'd0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_gate  <= '0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_gate  <= '0;
        end
      endcase
    end
  end

  assign req_ready_o   = ~r_busy;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign err_o         = r_err;
  assign pad_oe_gate_o = r_gate;
  assign pad_attr_o    = r_attr;

endmodule

// File: doc/prim_pad_attr_seq.md
PRIM_PAD_ATTR_SEQ -- requirements
Module: prim_pad_attr_seq

Interface
REQ-001 SHALL have parameter NumPads, default 8: number of pad channels, 1..64.
REQ-002 SHALL have parameter AttrDw, default 8: attribute bits per pad.
REQ-003 SHALL have parameter AttrWarlMask [AttrDw-1:0], default 8'h05: writable attribute bits for digital pads.
REQ-004 SHALL have parameter PadIsAnalog [NumPads-1:0], default '0: bit set means the pad is an analog feedthrough with no writable attributes.
REQ-005 SHALL have parameter SettleCycles, default 4, range 0..255: output-gate settle time before and after an attribute change.
REQ-006 SHALL use one clock and an asynchronous active-high reset, named clk_i and rst_i.
REQ-007 clk_i  input  1  clock; all state updates on its rising edge.
REQ-008 rst_i  input  1  asynchronous active-high reset.
REQ-009 req_i  input  1  attribute-write request valid.
REQ-010 req_ready_o  output  1  request accepted on a cycle where req_i and req_ready_o are both 1.
REQ-011 req_idx_i  input  IdxW  target pad index, where IdxW = max(1, $clog2(NumPads)).
REQ-012 req_attr_i  input  AttrDw  requested attribute value.
REQ-013 attr_warl_o  output  NumPads*AttrDw  per-pad writable mask, constant: 0 for analog pads, AttrWarlMask otherwise.
REQ-014 pad_attr_o  output  NumPads*AttrDw  current applied attributes; slice [i*AttrDw +: AttrDw] belongs to pad i.
REQ-015 pad_oe_gate_o  output  NumPads  1 forces the pad output-enable low during an update.
REQ-016 busy_o  output  1  sequence in progress.
REQ-017 done_o  output  1  one-cycle pulse: request completed.
REQ-018 err_o  output  1  one-cycle pulse: request rejected because req_idx_i >= NumPads.

Function
REQ-019 SHALL implement the FSM states IDLE, GATE, APPLY and HOLD.
REQ-020 req_ready_o SHALL be 1 only in IDLE; busy_o SHALL be 1 in GATE, APPLY and HOLD.
REQ-021 On acceptance, the block SHALL register idx and masked = req_attr_i & attr_warl_o[idx].
REQ-022 An out-of-range index SHALL cause err_o=1 in the next cycle, no state change, and leave pad_attr_o and pad_oe_gate_o untouched.
REQ-023 If masked equals the current pad_attr_o[idx] (no-op), done_o SHALL be 1 in the next cycle, the FSM SHALL remain in IDLE, and no gating SHALL occur.
REQ-024 Otherwise IDLE -> GATE; GATE SHALL last S = max(SettleCycles, 1) cycles, counted by a down-counter.
REQ-025 GATE -> APPLY; APPLY SHALL last 1 cycle, and pad_attr_o[idx] SHALL take the value masked at the end of APPLY.
REQ-026 APPLY -> HOLD; HOLD SHALL last S cycles, then the FSM SHALL return to IDLE.
REQ-027 Timeline, with acceptance at edge 0: pad_oe_gate_o[idx]=1 in cycles 1..2S+1; new attr visible from cycle S+2; done_o=1 and req_ready_o=1 in cycle 2S+2.
REQ-028 Only the targeted pad's gate bit SHALL assert, and at most one bit of pad_oe_gate_o SHALL be high at any time.
REQ-029 While busy, req_i SHALL be ignored, and req_idx_i/req_attr_i changes SHALL have no effect.
REQ-030 Non-writable bits of pad_attr_o SHALL always read 0.
REQ-031 done_o and err_o SHALL never be high in the same cycle.
REQ-032 A back-to-back request SHALL be acceptable in the same cycle done_o pulses.

Reset
REQ-033 While rst_i=1, regardless of the clock: FSM=IDLE, counter=0, pad_attr_o='0, pad_oe_gate_o='0, busy_o=0, done_o=0, err_o=0, req_ready_o=1.
REQ-034 Reset asserted mid-sequence SHALL abort the sequence without a done_o pulse, and all attributes SHALL revert to 0.

Verification (NumPads=8, AttrDw=8, mask 8'h05, SettleCycles=4 unless stated)
REQ-035 Reset: rst_i pulse -> all outputs as in REQ-033; attr_warl_o = {8{8'h05}}.
REQ-036 idx 3, attr 8'hFF at edge 0 -> pad_oe_gate_o=8'h08 in cycles 1..9; pad_attr_o[3]=8'h05 from cycle 6; done_o in cycle 10; req_ready_o=0 in cycles 1..9.
REQ-037 Repeat idx 3, attr 8'h07 -> masked value 8'h05 is unchanged, so done_o in cycle 1 and pad_oe_gate_o stays 0.
REQ-038 PadIsAnalog=8'h80, idx 7, attr 8'hFF -> no-op done_o in cycle 1; pad_attr_o[7]=0. With NumPads=6, idx 7 -> err_o in cycle 1 and no other change.
REQ-039 rst_i asserted in cycle 4 of a sequence -> gate 0 and attributes 0 immediately; no done_o; req_ready_o=1 after release.
REQ-040 req_i held high from cycle 0 with idx 2 then idx 5 -> second request accepted in cycle 10 (done_o cycle); pad_oe_gate_o=8'h20 in cycles 11..19. SettleCycles=0 -> gate spans 3 cycles.
